// File: rtl/seq_pkg.sv
// Shared types and constants for the sequencer instruction loader.
// Word layout: {flg[63:0], op_code[3:0], data[19:0], time_arg[31:0]}.
package seq_pkg;

    localparam int INSTR_W    = 120;
    localparam int WORD_BYTES = 15;

    localparam int FLG_MSB  = 119;
    localparam int FLG_LSB  = 56;
    localparam int OPC_MSB  = 55;
    localparam int OPC_LSB  = 52;
    localparam int DATA_MSB = 51;
    localparam int DATA_LSB = 32;
    localparam int TIME_MSB = 31;
    localparam int TIME_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_CSUM
    } ld_state_t;

endpackage

// File: rtl/seq_word_assembler.sv
// Packs a little-endian byte stream into one 120-bit instruction word.
// word_full flags the load that completes the current word.
module seq_word_assembler
    import seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               load,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_full
);

    logic [3:0] idx;

    assign word_full = load && (idx == 4'(WORD_BYTES - 1));

    // Bytes land in place, so the word stays stable until the next load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx  <= '0;
            word <= '0;
        end else if (load) begin
            word[{idx, 3'b000} +: 8] <= byte_in;
            idx <= word_full ? 4'd0 : idx + 4'd1;
        end
    end

endmodule

// File: rtl/sequence_loader.sv
// Streams a header + 15-byte words into sequencer instruction memory.
// Optional trailing XOR checksum: define SEQ_LOADER_CHECKSUM_EN.
module sequence_loader
    import seq_pkg::*;
#(
    parameter int ADDR_SIZE      = 15,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [INSTR_W-1:0]   mem_wdata,
    output logic                 mem_we,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_SIZE:0]   word_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] MAX_N = 17'd1 << ADDR_SIZE;

    typedef logic [ADDR_SIZE:0] cnt_t;

    ld_state_t state;
    logic      hdr_idx;
    logic [7:0] hdr_lo;
    cnt_t      n_words;
    cnt_t      wc_next;
    logic [TW-1:0] tcnt;
    logic [15:0] hdr_n;
    logic      loading;
    logic      accept;
    logic      tmo;
    logic      word_full;
    logic      clear;

    assign loading  = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
    assign rx_ready = loading;
    assign accept   = rx_valid && rx_ready;
    assign busy     = (state != S_IDLE);
    assign mem_we   = (state == S_WRITE);
    assign hdr_n    = {rx_data, hdr_lo};
    assign wc_next  = word_count + 1'b1;
    assign clear    = (state == S_IDLE) && start;
    assign tmo      = loading && !accept && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    seq_word_assembler u_asm (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .load     ((state == S_DATA) && accept),
        .byte_in  (rx_data),
        .word     (mem_wdata),
        .word_full(word_full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt <= '0;
        end else if (!loading || accept) begin
            tcnt <= '0;
        end else if (!tmo) begin
            tcnt <= tcnt + 1'b1;
        end
    end

`ifdef SEQ_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum <= '0;
        end else if (clear) begin
            csum <= '0;
        end else if (accept && (state != S_CSUM)) begin
            csum <= csum ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            hdr_idx    <= 1'b0;
            hdr_lo     <= '0;
            n_words    <= '0;
            mem_addr   <= '0;
            word_count <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tmo) begin
                error <= 1'b1;
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            state      <= S_HDR;
                            error      <= 1'b0;
                            word_count <= '0;
                            mem_addr   <= '0;
                            hdr_idx    <= 1'b0;
                        end
                    end
                    S_HDR: begin
                        if (accept) begin
                            if (!hdr_idx) begin
                                hdr_lo  <= rx_data;
                                hdr_idx <= 1'b1;
                            end else if (17'(hdr_n) > MAX_N) begin
                                error <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                n_words <= cnt_t'(hdr_n);
                                if (hdr_n == 16'd0) begin
`ifdef SEQ_LOADER_CHECKSUM_EN
                                    state <= S_CSUM;
`else
                                    state <= S_IDLE;
                                    done  <= 1'b1;
`endif
                                end else begin
                                    state <= S_DATA;
                                end
                            end
                        end
                    end
                    S_DATA: begin
                        if (word_full) state <= S_WRITE;
                    end
                    S_WRITE: begin
                        word_count <= wc_next;
                        // Saturate so a full-depth load never wraps to 0.
                        if (~&mem_addr) mem_addr <= mem_addr + 1'b1;
                        if (wc_next == n_words) begin
`ifdef SEQ_LOADER_CHECKSUM_EN
                            state <= S_CSUM;
`else
                            state <= S_IDLE;
                            done  <= 1'b1;
`endif
                        end else begin
                            state <= S_DATA;
                        end
                    end
`ifdef SEQ_LOADER_CHECKSUM_EN
                    S_CSUM: begin
                        if (accept) begin
                            if (rx_data == csum) done  <= 1'b1;
                            else                 error <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sequence_loader.sv
// Directed bench for sequence_loader (header, words, timeout, reset abort).
// Define SEQ_LOADER_CHECKSUM_EN to also cover the checksum trailer.
module tb_sequence_loader;

    localparam int AS = 15;
    localparam int TO = 40;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [AS-1:0] mem_addr;
    logic [119:0]  mem_wdata;
    logic          mem_we;
    logic          busy;
    logic          done;
    logic          error;
    logic [AS:0]   word_count;

    sequence_loader #(.ADDR_SIZE(AS), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    int bad_done = 0;
    logic [AS-1:0] wr_addr[$];
    logic [119:0]  wr_data[$];
    logic [7:0]    tb_csum = 8'h00;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            we_cnt++;
        end
        if (done) done_cnt++;
        if (done && error) bad_done++;
    end

    task automatic do_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tb_csum = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_byte_ready: rx_ready=%0b required 1", rx_ready);
        end
        tb_csum ^= b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_csum;
`ifdef SEQ_LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = tb_csum;
        send_byte(c);
`endif
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: done=%0b required 1", name, done);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({rx_ready, mem_addr, mem_wdata, mem_we, busy, done, error, word_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%0b addr=%0h we=%0b busy=%0b done=%0b err=%0b wc=%0d required all 0",
                     rx_ready, mem_addr, mem_we, busy, done, error, word_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word;
        int base = we_cnt;
        do_start;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: busy=%0b required 1", busy);
        end
        send_byte(8'h01);
        send_byte(8'h00);
        for (int k = 0; k < 15; k++) send_byte(8'(k));
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== '0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_write: we=%0b addr=%0h rdy=%0b required 1 0 0", mem_we, mem_addr, rx_ready);
        end
        checks++;
        if (mem_wdata !== 120'h0E0D0C0B0A09080706050403020100) begin
            errors++;
            $display("FAIL single_wdata: got %h required 0e0d0c0b0a09080706050403020100", mem_wdata);
        end
        @(negedge clk);
        send_csum;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL single_done: done=%0b busy=%0b err=%0b required 1 0 0", done, busy, error);
        end
        checks++;
        if (word_count !== 16'd1) begin
            errors++;
            $display("FAIL single_wc: word_count=%0d required 1", word_count);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || we_cnt - base !== 1) begin
            errors++;
            $display("FAIL single_pulse: done=%0b writes=%0d required 0 1", done, we_cnt - base);
        end
    endtask

    task automatic test_three_gapped;
        logic [119:0] exp_w[3];
        int base;
        exp_w[0] = 120'h0E0D0C0B0A09080706050403020100;
        exp_w[1] = 120'h1E1D1C1B1A19181716151413121110;
        exp_w[2] = 120'h2E2D2C2B2A29282726252423222120;
        wr_addr.delete();
        wr_data.delete();
        base = we_cnt;
        do_start;
        send_byte(8'h03);
        @(negedge clk);
        send_byte(8'h00);
        @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 15; k++) begin
                send_byte(8'(w * 16 + k));
                @(negedge clk);
            end
        end
        send_csum;
        wait_done("three");
        #1;
        checks++;
        if (we_cnt - base !== 3 || wr_addr.size() != 3) begin
            errors++;
            $display("FAIL three_count: writes=%0d required 3", we_cnt - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr[i] !== AS'(i) || wr_data[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL three_word%0d: addr=%0h data=%h required addr %0h data %h",
                             i, wr_addr[i], wr_data[i], i, exp_w[i]);
                end
            end
        end
        checks++;
        if (word_count !== 16'd3) begin
            errors++;
            $display("FAIL three_wc: word_count=%0d required 3", word_count);
        end
    endtask

    task automatic test_oversize;
        int base = we_cnt;
        int dbase = done_cnt;
        do_start;
        send_byte(8'h01);
        send_byte(8'h80);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL oversize_abort: err=%0b busy=%0b done=%0b required 1 0 0", error, busy, done);
        end
        @(negedge clk);
        #1;
        checks++;
        if (we_cnt !== base || done_cnt !== dbase) begin
            errors++;
            $display("FAIL oversize_nowrite: writes=%0d dones=%0d required 0 0", we_cnt - base, done_cnt - dbase);
        end
    endtask

    task automatic test_zero_words;
        int base = we_cnt;
        start = 1'b1;
        rx_valid = 1'b1;
        rx_data = 8'h00;
        #1;
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: rx_ready=%0b required 0", rx_ready);
        end
        @(negedge clk);
        start = 1'b0;
        tb_csum = 8'h00;
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_error: err=%0b required 0", error);
        end
        send_byte(8'h00);
        start = 1'b1;
        send_byte(8'h00);
        start = 1'b0;
        send_csum;
        wait_done("zero");
        #1;
        checks++;
        if (word_count !== '0 || we_cnt !== base || error !== 1'b0) begin
            errors++;
            $display("FAIL zero_result: wc=%0d writes=%0d err=%0b required 0 0 0", word_count, we_cnt - base, error);
        end
    endtask

    task automatic test_timeout;
        int base = we_cnt;
        int dbase = done_cnt;
        do_start;
        send_byte(8'h01);
        send_byte(8'h00);
        for (int k = 0; k < 14; k++) send_byte(8'(k));
        repeat (TO - 1) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: busy=%0b err=%0b required 1 0", busy, error);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("FAIL timeout_abort: busy=%0b err=%0b required 0 1", busy, error);
        end
        #1;
        checks++;
        if (we_cnt !== base || done_cnt !== dbase) begin
            errors++;
            $display("FAIL timeout_nowrite: writes=%0d dones=%0d required 0 0", we_cnt - base, done_cnt - dbase);
        end
    endtask

    task automatic test_reset_mid_load;
        int base = we_cnt;
        int dbase = done_cnt;
        do_start;
        send_byte(8'h02);
        send_byte(8'h00);
        for (int k = 0; k < 15; k++) send_byte(8'(k));
        for (int k = 0; k < 5; k++) send_byte(8'(8'h50 + k));
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rx_ready, mem_addr, mem_wdata, mem_we, busy, done, error, word_count} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: rdy=%0b addr=%0h we=%0b busy=%0b done=%0b err=%0b wc=%0d required all 0",
                     rx_ready, mem_addr, mem_we, busy, done, error, word_count);
        end
        checks++;
        if (we_cnt - base !== 1 || done_cnt !== dbase) begin
            errors++;
            $display("FAIL midreset_partial: writes=%0d dones=%0d required 1 0", we_cnt - base, done_cnt - dbase);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        base = we_cnt;
        do_start;
        send_byte(8'h01);
        send_byte(8'h00);
        for (int k = 0; k < 15; k++) send_byte(8'(8'hA0 + k));
        send_csum;
        wait_done("reload");
        #1;
        checks++;
        if (we_cnt - base !== 1 || wr_addr.size() != 1) begin
            errors++;
            $display("FAIL reload_count: writes=%0d required 1", we_cnt - base);
        end else begin
            checks++;
            if (wr_addr[0] !== '0 || wr_data[0] !== 120'hAEADACABAAA9A8A7A6A5A4A3A2A1A0) begin
                errors++;
                $display("FAIL reload_word: addr=%0h data=%h required 0 aeadacabaaa9a8a7a6a5a4a3a2a1a0",
                         wr_addr[0], wr_data[0]);
            end
        end
    endtask

`ifdef SEQ_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        int base = we_cnt;
        int dbase;
        do_start;
        send_byte(8'h01);
        send_byte(8'h00);
        for (int k = 0; k < 15; k++) send_byte(8'(k));
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rx_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL csum_wait: busy=%0b rdy=%0b done=%0b required 1 1 0", busy, rx_ready, done);
        end
        send_byte(8'h0E);
        checks++;
        if (done !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL csum_good: done=%0b err=%0b required 1 0", done, error);
        end
        @(negedge clk);
        #1;
        dbase = done_cnt;
        do_start;
        send_byte(8'h01);
        send_byte(8'h00);
        for (int k = 0; k < 15; k++) send_byte(8'(k));
        @(negedge clk);
        send_byte(8'h0F);
        checks++;
        if (done !== 1'b0 || error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL csum_bad: done=%0b err=%0b busy=%0b required 0 1 0", done, error, busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (done_cnt !== dbase || we_cnt - base !== 2) begin
            errors++;
            $display("FAIL csum_bad_effects: dones=%0d writes=%0d required 0 2", done_cnt - dbase, we_cnt - base);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_single_word;
        test_three_gapped;
        test_oversize;
        test_zero_words;
        test_timeout;
        test_reset_mid_load;
`ifdef SEQ_LOADER_CHECKSUM_EN
        test_checksum;
`endif
        checks++;
        if (bad_done !== 0) begin
            errors++;
            $display("FAIL done_with_error: cycles=%0d required 0", bad_done);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
